// File: rtl/stf_preamble_inserter.sv
// ---------------------------------------------------------------------------
// stf_preamble_inserter
//
// TX-side short-training-field inserter. Every AXI-Stream I/Q payload packet
// is preceded by SHORT_REPS repetitions of a programmable SHORT_LEN-sample
// short symbol held in a small pattern RAM. An optional run of GAP_LEN zero
// samples follows each packet. This gives the receiver's autocorrelator a
// clean plateau to lock onto.
//
// Parameters
//   SHORT_LEN  : samples per short symbol (power of two, 1..16)
//   SHORT_REPS : short-symbol repetitions per preamble (1..255)
//   GAP_LEN    : zero samples after each packet's tlast (0 = no gap)
//
// Optional build macro
//   STF_PREAMBLE_WINDOW_EN : when defined, the first preamble beat of each
//   frame (pattern[0]) and the first gap beat (the last payload sample) are
//   emitted at half amplitude. Each of I and Q is shifted right
//   arithmetically by one, which gives a soft transition window.
//
// Ports
//   clk, reset      : clock, synchronous active-high reset (clears pattern RAM)
//   clear           : synchronous soft clear, pattern RAM retained
//   pat_we/addr/data: pattern RAM write port, sample = {I[31:16], Q[15:0]}
//   i_t*            : payload AXI-Stream slave
//   o_t*            : output AXI-Stream master
//   busy            : high whenever the FSM is not idle
//   frame_count     : completed frames, wraps modulo 2^16
// ---------------------------------------------------------------------------
module stf_preamble_inserter #(
    parameter int SHORT_LEN  = 16,
    parameter int SHORT_REPS = 10,
    parameter int GAP_LEN    = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        pat_we,
    input  logic [3:0]  pat_addr,
    input  logic [31:0] pat_data,
    input  logic [31:0] i_tdata,
    input  logic        i_tlast,
    input  logic        i_tvalid,
    output logic        i_tready,
    output logic [31:0] o_tdata,
    output logic        o_tlast,
    output logic        o_tvalid,
    input  logic        o_tready,
    output logic        busy,
    output logic [15:0] frame_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_PAYLOAD,
        ST_GAP
    } state_t;

    localparam logic [3:0]  IDX_LAST = 4'(SHORT_LEN - 1);
    localparam logic [7:0]  REP_LAST = 8'(SHORT_REPS - 1);
    localparam bit          HAS_GAP  = (GAP_LEN > 0);
    localparam logic [15:0] GAP_LAST = HAS_GAP ? 16'(GAP_LEN - 1) : 16'd0;

    state_t      state;
    logic [3:0]  sample_idx;
    logic [7:0]  rep_cnt;
    logic [15:0] gap_cnt;
    logic [31:0] pattern_ram [16];
    logic        out_fire;
    logic        in_fire;

`ifdef STF_PREAMBLE_WINDOW_EN
    logic [31:0] last_payload;

    // Halve both I and Q while keeping their sign (arithmetic shift by one).
    function automatic logic [31:0] halve(input logic [31:0] s);
        return {s[31], s[31:17], s[15], s[15:1]};
    endfunction
`endif

    assign out_fire = o_tvalid & o_tready;
    assign in_fire  = i_tvalid & i_tready;
    assign busy     = (state != ST_IDLE);

    // The pattern RAM is a plain register file with an asynchronous read.
    // Writes land at the clock edge and are visible on the next cycle, even
    // mid-preamble. Only a hard reset wipes it; a soft clear keeps it so the
    // host does not have to reload the symbol after aborting a frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                pattern_ram[i] <= 32'd0;
            end
        end else if (pat_we) begin
            pattern_ram[pat_addr] <= pat_data;
        end
    end

    // Main sequencer. The preamble walks sample_idx through one short symbol
    // and counts symbols in rep_cnt. The payload is forwarded untouched until
    // its tlast beat, and the optional gap counts zero beats. Either reset
    // source abandons an in-flight frame without counting it.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state        <= ST_IDLE;
            sample_idx   <= 4'd0;
            rep_cnt      <= 8'd0;
            gap_cnt      <= 16'd0;
            frame_count  <= 16'd0;
`ifdef STF_PREAMBLE_WINDOW_EN
            last_payload <= 32'd0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_tvalid) begin
                        state <= ST_PREAMBLE;
                    end
                end

                ST_PREAMBLE: begin
                    if (out_fire) begin
                        if (sample_idx == IDX_LAST) begin
                            sample_idx <= 4'd0;
                            if (rep_cnt == REP_LAST) begin
                                rep_cnt <= 8'd0;
                                state   <= ST_PAYLOAD;
                            end else begin
                                rep_cnt <= rep_cnt + 8'd1;
                            end
                        end else begin
                            sample_idx <= sample_idx + 4'd1;
                        end
                    end
                end

                ST_PAYLOAD: begin
                    if (in_fire) begin
`ifdef STF_PREAMBLE_WINDOW_EN
                        last_payload <= i_tdata;
`endif
                        if (i_tlast) begin
                            frame_count <= frame_count + 16'd1;
                            state       <= HAS_GAP ? ST_GAP : ST_IDLE;
                        end
                    end
                end

                ST_GAP: begin
                    if (out_fire) begin
                        if (gap_cnt == GAP_LAST) begin
                            gap_cnt <= 16'd0;
                            state   <= ST_IDLE;
                        end else begin
                            gap_cnt <= gap_cnt + 16'd1;
                        end
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Output steering. Preamble and gap beats are sourced locally, and the
    // payload path is a zero-latency combinational pass-through so that the
    // upstream source sees the radio's backpressure directly.
    always_comb begin
        o_tvalid = 1'b0;
        o_tdata  = 32'd0;
        o_tlast  = 1'b0;
        i_tready = 1'b0;
        case (state)
            ST_PREAMBLE: begin
                o_tvalid = 1'b1;
                o_tdata  = pattern_ram[sample_idx];
`ifdef STF_PREAMBLE_WINDOW_EN
                if ((sample_idx == 4'd0) && (rep_cnt == 8'd0)) begin
                    o_tdata = halve(pattern_ram[0]);
                end
`endif
            end
            ST_PAYLOAD: begin
                o_tvalid = i_tvalid;
                o_tdata  = i_tdata;
                o_tlast  = i_tlast;
                i_tready = o_tready;
            end
            ST_GAP: begin
                o_tvalid = 1'b1;
                o_tdata  = 32'd0;
`ifdef STF_PREAMBLE_WINDOW_EN
                if (gap_cnt == 16'd0) begin
                    o_tdata = halve(last_payload);
                end
`endif
            end
            default: begin
                o_tvalid = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_stf_preamble_inserter.sv
// ---------------------------------------------------------------------------
// tb_stf_preamble_inserter
//
// Self-checking bench for stf_preamble_inserter (SHORT_LEN 16, SHORT_REPS 10,
// GAP_LEN 8). Each packet pushes its full expected beat stream (preamble,
// payload, gap) into a scoreboard queue. A negedge monitor pops and compares
// every beat that transfers. A table of packets covers the main flow. Hand
// sequences cover reset/clear aborts, a pattern write mid-preamble and the
// optional window feature.
// ---------------------------------------------------------------------------
module tb_stf_preamble_inserter;

    localparam int SHORT_LEN  = 16;
    localparam int SHORT_REPS = 10;
    localparam int GAP        = 8;
    localparam int PRE_BEATS  = SHORT_LEN * SHORT_REPS;

    logic        clk;
    logic        reset;
    logic        clear;
    logic        pat_we;
    logic [3:0]  pat_addr;
    logic [31:0] pat_data;
    logic [31:0] i_tdata;
    logic        i_tlast;
    logic        i_tvalid;
    logic        i_tready;
    logic [31:0] o_tdata;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready;
    logic        busy;
    logic [15:0] frame_count;

    stf_preamble_inserter #(
        .SHORT_LEN (SHORT_LEN),
        .SHORT_REPS(SHORT_REPS),
        .GAP_LEN   (GAP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .pat_we     (pat_we),
        .pat_addr   (pat_addr),
        .pat_data   (pat_data),
        .i_tdata    (i_tdata),
        .i_tlast    (i_tlast),
        .i_tvalid   (i_tvalid),
        .i_tready   (i_tready),
        .o_tdata    (o_tdata),
        .o_tlast    (o_tlast),
        .o_tvalid   (o_tvalid),
        .o_tready   (o_tready),
        .busy       (busy),
        .frame_count(frame_count)
    );

    typedef struct {
        int          len;
        bit          toggle;
        logic [31:0] base;
        logic [15:0] exp_frames;
    } vec_t;

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [32:0] exp_q[$];
    logic [32:0] src_q[$];
    logic [31:0] model_pat[16];
    bit          src_fire    = 1'b0;
    bit          mon_en      = 1'b0;
    bit          toggle_ready = 1'b0;
    bit          prev_stall  = 1'b0;
    logic [31:0] prev_data   = 32'd0;
    int          beat_cnt    = 0;
    int          cyc         = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference halving, written as a signed shift on each component.
    function automatic logic [31:0] halfAmp(input logic [31:0] d);
        logic signed [15:0] i_part;
        logic signed [15:0] q_part;
        i_part = d[31:16];
        q_part = d[15:0];
        i_part = i_part >>> 1;
        q_part = q_part >>> 1;
        return {i_part, q_part};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every transferred beat against the scoreboard and
    // make sure a stalled beat is held unchanged into the next cycle.
    always @(negedge clk) begin
        logic [32:0] e;
        src_fire = i_tvalid && i_tready;
        if (mon_en) begin
            if (prev_stall) begin
                checkOutput("stall_hold", {31'd0, o_tvalid, o_tdata}, {31'd0, 1'b1, prev_data});
            end
            if (o_tvalid && o_tready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("[TB] FAIL unexpected_beat: got %h, expected no beat", {o_tlast, o_tdata});
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("beat", {31'd0, o_tlast, o_tdata}, {31'd0, e});
                end
                beat_cnt++;
            end
            prev_stall = o_tvalid && !o_tready;
            prev_data  = o_tdata;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Payload source and output-ready driver, updated just after each edge.
    always @(posedge clk) begin
        logic [32:0] tmp;
        #1;
        cyc++;
        if (src_fire && src_q.size() > 0) begin
            tmp = src_q.pop_front();
        end
        if (src_q.size() > 0) begin
            i_tvalid = 1'b1;
            {i_tlast, i_tdata} = src_q[0];
        end else begin
            i_tvalid = 1'b0;
            i_tlast  = 1'b0;
            i_tdata  = 32'd0;
        end
        o_tready = toggle_ready ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
    end

    // Queue one packet's source samples and its full expected output stream.
    task automatic pushPacket(input int len, input logic [31:0] base);
        logic [31:0] d;
        beat_cnt = 0;
        for (int r = 0; r < SHORT_REPS; r++) begin
            for (int s = 0; s < SHORT_LEN; s++) begin
                d = model_pat[s];
`ifdef STF_PREAMBLE_WINDOW_EN
                if (r == 0 && s == 0) d = halfAmp(d);
`endif
                exp_q.push_back({1'b0, d});
            end
        end
        for (int i = 0; i < len; i++) begin
            d = base + 32'(i);
            exp_q.push_back({(i == len - 1), d});
        end
        for (int g = 0; g < GAP; g++) begin
            d = 32'd0;
`ifdef STF_PREAMBLE_WINDOW_EN
            if (g == 0) d = halfAmp(base + 32'(len - 1));
`endif
            exp_q.push_back({1'b0, d});
        end
        for (int i = 0; i < len; i++) begin
            src_q.push_back({(i == len - 1), base + 32'(i)});
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        @(posedge clk); #1;
        toggle_ready = v.toggle;
        pushPacket(v.len, v.base);
    endtask

    // Wait for the scoreboard to drain, then check busy drops right after.
    task automatic waitDrain(input string name);
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 3000) begin
            @(negedge clk); #2;
            guard++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fails++;
            $display("[TB] FAIL %s_timeout: %0d beats still pending, expected 0", name, exp_q.size());
            exp_q.delete();
            src_q.delete();
        end else begin
            checkOutput({name, "_busy_last"}, {63'd0, busy}, 64'd1);
            @(posedge clk); #1;
            checkOutput({name, "_busy_after"}, {63'd0, busy}, 64'd0);
        end
    endtask

    task automatic waitBeats(input int n);
        int guard;
        guard = 0;
        while (beat_cnt < n && guard < 3000) begin
            @(negedge clk); #2;
            guard++;
        end
        if (beat_cnt < n) begin
            n_checks++;
            n_fails++;
            $display("[TB] FAIL wait_beats: got %0d beats, expected %0d", beat_cnt, n);
        end
    endtask

    task automatic abortWith(input bit use_clear);
        @(posedge clk); #1;
        mon_en = 1'b0;
        src_q.delete();
        exp_q.delete();
        if (use_clear) clear = 1'b1;
        else           reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        clear = 1'b0;
        checkOutput("abort_tvalid", {63'd0, o_tvalid}, 64'd0);
        checkOutput("abort_busy", {63'd0, busy}, 64'd0);
        checkOutput("abort_frames", {48'd0, frame_count}, 64'd0);
        if (!use_clear) begin
            for (int n = 0; n < 16; n++) model_pat[n] = 32'd0;
        end
        mon_en = 1'b1;
    endtask

    task automatic loadPattern();
        for (int n = 0; n < 16; n++) begin
            @(posedge clk); #1;
            pat_we   = 1'b1;
            pat_addr = 4'(n);
            pat_data = {16'(n), 16'h8000 + 16'(n)};
            model_pat[n] = pat_data;
        end
        @(posedge clk); #1;
        pat_we = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[4];
        vecs[0] = '{4, 1'b0, 32'hA0A0_0000, 16'd1};
        vecs[1] = '{4, 1'b1, 32'hA0A0_0000, 16'd2};
        vecs[2] = '{1, 1'b0, 32'h0010_FFF0, 16'd3};
        vecs[3] = '{3, 1'b1, 32'h7FFF_8001, 16'd4};

        reset = 1'b1; clear = 1'b0; pat_we = 1'b0; pat_addr = 4'd0; pat_data = 32'd0;
        i_tdata = 32'd0; i_tlast = 1'b0; i_tvalid = 1'b0; o_tready = 1'b1;
        for (int n = 0; n < 16; n++) model_pat[n] = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        checkOutput("reset_tvalid", {63'd0, o_tvalid}, 64'd0);
        checkOutput("reset_tready", {63'd0, i_tready}, 64'd0);
        checkOutput("reset_tlast", {63'd0, o_tlast}, 64'd0);
        checkOutput("reset_busy", {63'd0, busy}, 64'd0);
        checkOutput("reset_frames", {48'd0, frame_count}, 64'd0);
        mon_en = 1'b1;

        $display("[TB] reset abort at preamble beat 50");
        loadPattern();
        @(posedge clk); #1;
        pushPacket(4, 32'hB0B0_0000);
        waitBeats(50);
        abortWith(1'b0);

        $display("[TB] zero pattern after reset, then clear abort");
        @(posedge clk); #1;
        pushPacket(4, 32'hB0B0_0000);
        waitBeats(20);
        abortWith(1'b1);

        $display("[TB] clear abort keeps pattern");
        loadPattern();
        @(posedge clk); #1;
        pushPacket(4, 32'hB0B0_0000);
        waitBeats(50);
        abortWith(1'b1);

        $display("[TB] packet table");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i]);
            waitDrain("pkt");
            checkOutput("frame_count", {48'd0, frame_count}, {48'd0, vecs[i].exp_frames});
        end
        toggle_ready = 1'b0;

        $display("[TB] pattern write during repetition 3 sample 2");
        @(posedge clk); #1;
        pushPacket(2, 32'hC0C0_0000);
        for (int r = 3; r < SHORT_REPS; r++) exp_q[r * SHORT_LEN + 5] = {1'b0, 32'h1234_5678};
        waitBeats(50);
        @(posedge clk); #1;
        pat_we = 1'b1; pat_addr = 4'd5; pat_data = 32'h1234_5678;
        @(posedge clk); #1;
        pat_we = 1'b0;
        model_pat[5] = 32'h1234_5678;
        waitDrain("midwrite");
        checkOutput("frame_count", {48'd0, frame_count}, 64'd5);

`ifdef STF_PREAMBLE_WINDOW_EN
        $display("[TB] transition window");
        @(posedge clk); #1;
        pat_we = 1'b1; pat_addr = 4'd0; pat_data = {16'h8000, 16'h7FFE};
        model_pat[0] = pat_data;
        @(posedge clk); #1;
        pat_we = 1'b0;
        pushPacket(2, 32'h0010_FFEF);
        exp_q[0] = {1'b0, 32'hC000_3FFF};
        exp_q[PRE_BEATS + 2] = {1'b0, 32'h0008_FFF8};
        waitDrain("window");
        checkOutput("frame_count", {48'd0, frame_count}, 64'd6);
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
